// File: rtl/pacman_mover.sv
// Pac-Man sprite position owner: once per frame (vsync falling edge) it moves the sprite
// by one step in the latched key direction and publishes X then Y over the active-low memWr bus.
module pacman_mover #(
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned SPRITE_SIZE = 32,
   parameter int unsigned STEP        = 4,
   parameter int unsigned START_X     = 304,
   parameter int unsigned START_Y     = 224,
   parameter logic [7:0]  KEY_UP      = 8'h57,
   parameter logic [7:0]  KEY_DOWN    = 8'h53,
   parameter logic [7:0]  KEY_LEFT    = 8'h41,
   parameter logic [7:0]  KEY_RIGHT   = 8'h44
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic [7:0]  letra,
   input  logic        enable,
   output logic        memWr,
   output logic [31:0] address,
   output logic [31:0] datoOut,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        busy
);

   localparam int unsigned POS_W  = 10;
   localparam int unsigned CALC_W = 11;
   localparam logic [CALC_W-1:0] MAX_X  = CALC_W'(SCREEN_W - SPRITE_SIZE);
   localparam logic [CALC_W-1:0] MAX_Y  = CALC_W'(SCREEN_H - SPRITE_SIZE);
   localparam logic [CALC_W-1:0] STEP_V = CALC_W'(STEP);

   typedef enum logic [2:0] {INIT, IDLE, UPDATE, WR_X, WR_Y} state_t;
   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   state_t            state, next_state;
   dir_t              dir, next_dir, key_dir;
   logic              pending, next_pending;
   logic              vs_d;
   logic              tick;
   logic [POS_W-1:0]  next_x, next_y;
   logic [CALC_W-1:0] x_ext, y_ext, x_sum, y_sum;

   assign tick = vs_d & ~vsync;

   // Next-state, direction latch and clamped movement
   always_comb begin
      next_state   = state;
      next_pending = pending;
      next_dir     = dir;
      next_x       = pos_x;
      next_y       = pos_y;
      x_ext        = {1'b0, pos_x};
      y_ext        = {1'b0, pos_y};
      x_sum        = x_ext + STEP_V;
      y_sum        = y_ext + STEP_V;
      key_dir      = dir;

      if (letra == KEY_UP)         key_dir = DIR_UP;
      else if (letra == KEY_DOWN)  key_dir = DIR_DOWN;
      else if (letra == KEY_LEFT)  key_dir = DIR_LEFT;
      else if (letra == KEY_RIGHT) key_dir = DIR_RIGHT;

      case (state)
         INIT: begin
            next_state = WR_X;
            if (tick) next_pending = 1'b1;
         end
         IDLE: begin
            if (!enable) begin
               next_pending = 1'b0;
            end else if (tick || pending) begin
               next_state   = UPDATE;
               next_pending = 1'b0;
            end
         end
         UPDATE: begin
            if (tick) next_pending = 1'b1;
            next_dir   = key_dir;
            next_state = WR_X;
            case (key_dir)
               DIR_LEFT:  next_x = (x_ext < STEP_V) ? '0 : POS_W'(x_ext - STEP_V);
               DIR_RIGHT: next_x = POS_W'((x_sum > MAX_X) ? MAX_X : x_sum);
               DIR_UP:    next_y = (y_ext < STEP_V) ? '0 : POS_W'(y_ext - STEP_V);
               DIR_DOWN:  next_y = POS_W'((y_sum > MAX_Y) ? MAX_Y : y_sum);
               default:   ;
            endcase
         end
         WR_X: begin
            if (tick) next_pending = 1'b1;
            next_state = WR_Y;
         end
         WR_Y: begin
            if (tick) next_pending = 1'b1;
            next_state = IDLE;
         end
         default: next_state = INIT;
      endcase
   end

   // State, position and bus outputs; bus fields are derived from next_state so they line up with WR_X/WR_Y
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= INIT;
         dir     <= DIR_NONE;
         pending <= 1'b0;
         vs_d    <= 1'b1;
         pos_x   <= POS_W'(START_X);
         pos_y   <= POS_W'(START_Y);
         memWr   <= 1'b1;
         address <= '0;
         datoOut <= '0;
         busy    <= 1'b1;
      end else begin
         state   <= next_state;
         dir     <= next_dir;
         pending <= next_pending;
         vs_d    <= vsync;
         pos_x   <= next_x;
         pos_y   <= next_y;
         memWr   <= !((next_state == WR_X) || (next_state == WR_Y));
         address <= (next_state == WR_Y) ? 32'd1 : 32'd0;
         if (next_state == WR_X)      datoOut <= 32'(next_x);
         else if (next_state == WR_Y) datoOut <= 32'(next_y);
         else                         datoOut <= '0;
         busy    <= (next_state != IDLE);
      end
   end

endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
Upstream stage of vga_controller that owns the Pac-Man sprite position. Once per frame (vsync falling edge) it samples the key code on letra, updates a latched direction, and moves the sprite by STEP pixels, clamped to the visible area. It then issues two bus writes (X to address 0, Y to address 1) using the same active-low memWr protocol that vga_controller decodes.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
SPRITE_SIZE, 32, sprite edge in pixels
STEP, 4, pixels moved per frame
START_X, 304, X position after reset
START_Y, 224, Y position after reset
KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 8'h57 / 8'h53 / 8'h41 / 8'h44, key codes for W / S / A / D

Ports:
clk  in  1  system clock, same clock that drives vga_controller clock_in
rst  in  1  synchronous, active-low reset
vsync  in  1  vsync from vga_controller (active-low pulse)
letra  in  8  current key code
enable  in  1  1 = movement allowed, 0 = paused
memWr  out  1  active-low write strobe to vga_controller
address  out  32  0 = X register, 1 = Y register
datoOut  out  32  write data, zero-extended position
pos_x  out  10  current X position
pos_y  out  10  current Y position
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at a clk edge): pos_x=START_X, pos_y=START_Y, dir=NONE, pending=0, vs_d=1, memWr=1, address=0, datoOut=0, state=INIT.
- Tick: tick=1 in the cycle where vs_d=1 and vsync=0. vs_d registers vsync every cycle.
- States:
  - INIT: goes to WR_X next cycle. This publishes the start position.
  - IDLE: if tick or pending, and enable=1, go to UPDATE and clear pending. If enable=0, drop the tick and clear pending.
  - UPDATE: one cycle. Latch dir from letra if letra matches one of the four key codes; any other code keeps the old dir. Compute and register the new position using the newly latched dir. Go to WR_X.
  - WR_X: memWr=0, address=0, datoOut={22'b0,pos_x}. Go to WR_Y.
  - WR_Y: memWr=0, address=1, datoOut={22'b0,pos_y}. Go to IDLE.
- Outside WR_X and WR_Y: memWr=1, address=0, datoOut=0. All three are registered outputs.
- Latency: tick at cycle T gives UPDATE at T+1, the X write at T+2 and the Y write at T+3.
- Movement arithmetic (11-bit unsigned, no wrap):
  - LEFT: x = (x<STEP) ? 0 : x-STEP
  - RIGHT: x = min(x+STEP, SCREEN_W-SPRITE_SIZE)
  - UP: y = (y<STEP) ? 0 : y-STEP
  - DOWN: y = min(y+STEP, SCREEN_H-SPRITE_SIZE)
  - NONE: no change
  - Only one axis moves per frame.
- Writes occur every frame even if the position is unchanged.
- A tick arriving in INIT, UPDATE, WR_X or WR_Y sets pending=1. At most one pending tick is kept; further ticks are lost.
- Reset asserted mid-write: next cycle memWr=1 and state=INIT. The start position is rewritten two cycles after rst is released.
- A held-low vsync produces only one tick. Glitch filtering is not this block's job.

Test Plan:
- Reset sequence: hold rst=0 for 3 cycles, then release → memWr=0 with address=0 and datoOut=304, then next cycle address=1 and datoOut=224; busy=0 afterwards.
- Move right: letra=8'h44, vsync falling edge at T → at T+2 write address 0 with data 308; at T+3 write address 1 with data 224. A second tick with letra=0 → x=312 (direction persists).
- Right clamp: x=606, dir RIGHT, tick → x=608; another tick → x=608, writes still issued.
- Left/up floor: x=2 with LEFT → 0. y=3 with UP → 0. No underflow to 1023.
- Pending tick: second vsync falling edge during WR_X → after WR_Y, UPDATE runs with no new edge and x advances by STEP again. Three ticks within 4 cycles → only two updates.
- Pause and reset: enable=0, tick → no memWr pulse and position held. rst=0 during WR_Y → memWr=1 next cycle and position=(304,224).
